manual_drive_fsm: RTL and testbench

MANUAL_DRIVE_FSM -- requirements
Module: manual_drive_fsm

---
 rtl/manual_drive_fsm_pkg.sv | 67 ++++++
 rtl/tick_counter.sv | 30 +++
 rtl/manual_drive_fsm.sv | 110 +++++++++++
 tb/tb_manual_drive_fsm.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/manual_drive_fsm_pkg.sv
// Shared car definitions: drive-state encodings, indicator side selection,
// and the drive-state transition rules used by the engine FSM.
package manual_drive_fsm_pkg;

    typedef enum logic [1:0] {
        DS_OFF          = 2'b00,
        DS_NOT_STARTING = 2'b01,
        DS_STARTING     = 2'b10,
        DS_MOVING       = 2'b11
    } drive_state_e;

    typedef enum logic [1:0] {
        SIDE_NONE  = 2'b00,
        SIDE_LEFT  = 2'b01,
        SIDE_RIGHT = 2'b10
    } side_e;

    localparam logic [15:0] MILEAGE_MAX = 16'hFFFF;

    // Exactly one lever pressed selects a side; both or neither selects none.
    function automatic side_e select_side(input logic left, input logic right);
        side_e side;
        side = SIDE_NONE;
        if (left && !right) side = SIDE_LEFT;
        else if (right && !left) side = SIDE_RIGHT;
        return side;
    endfunction

    function automatic drive_state_e next_drive_state(
        input drive_state_e state,
        input logic         hold_done,
        input logic         power_off,
        input logic         throttle,
        input logic         clutch,
        input logic         brake,
        input logic         reverse_edge
    );
        drive_state_e nxt;
        // NOTE: the result gets a default before any branch, so no path can
        // leave it unassigned and combinational users never infer a latch.
        nxt = state;
        if (state != DS_OFF && power_off) begin
            nxt = DS_OFF;
        end else begin
            case (state)
                DS_OFF: begin
                    if (hold_done) nxt = DS_NOT_STARTING;
                end
                DS_NOT_STARTING: begin
                    if (!brake && throttle) nxt = clutch ? DS_STARTING : DS_OFF;
                end
                DS_STARTING: begin
                    if (brake) nxt = DS_NOT_STARTING;
                    else if (throttle && !clutch) nxt = DS_MOVING;
                end
                DS_MOVING: begin
                    if (brake) nxt = DS_NOT_STARTING;
                    else if (reverse_edge && !clutch) nxt = DS_OFF;
                    else if (clutch || !throttle) nxt = DS_STARTING;
                end
                default: nxt = DS_OFF;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Free-running divider: one-cycle tick on every N-th enabled cycle.
// clr outranks en and suppresses the tick, restarting the count from zero.
module tick_counter #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    assign tick = en && !clr && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/manual_drive_fsm.sv
// Manual-gearbox car drive controller: power-up hold, start/move sequencing,
// mileage accumulation and blinking turn indicators, all outputs registered.
module manual_drive_fsm
    import manual_drive_fsm_pkg::*;
#(
    parameter int POWER_ON_HOLD = 100_000_000,
    parameter int UNIT_CYCLES   = 100_000_000,
    parameter int BLINK_HALF    = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power_on,
    input  logic        power_off,
    input  logic        throttle,
    input  logic        clutch,
    input  logic        brake,
    input  logic        reverse,
    input  logic        left,
    input  logic        right,
    output logic [1:0]  drive_state,
    output logic        powered,
    output logic        reverse_mode,
    output logic        turn_left_led,
    output logic        turn_right_led,
    output logic [15:0] mileage
);

    drive_state_e state;
    drive_state_e next_state;
    side_e        side;
    side_e        side_q;
    logic         hold_en;
    logic         hold_done;
    logic         unit_tick;
    logic         blink_tick;
    logic         going_off;
    logic         newly_selected;

    assign hold_en = (state == DS_OFF) && power_on && !power_off;

    tick_counter #(.N(POWER_ON_HOLD)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .en   (hold_en),
        .clr  (!hold_en),
        .tick (hold_done)
    );

    assign next_state = next_drive_state(state, hold_done, power_off, throttle,
                                         clutch, brake, reverse != reverse_mode);
    assign going_off  = (next_state == DS_OFF);

    // Partial mileage units survive braking; only powering down discards them.
    tick_counter #(.N(UNIT_CYCLES)) u_unit (
        .clk  (clk),
        .rst  (rst),
        .en   (state == DS_MOVING),
        .clr  (going_off),
        .tick (unit_tick)
    );

    assign side           = going_off ? SIDE_NONE : select_side(left, right);
    assign newly_selected = (side != side_q);

    tick_counter #(.N(BLINK_HALF)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .en   (side != SIDE_NONE),
        .clr  (newly_selected || side == SIDE_NONE),
        .tick (blink_tick)
    );

    assign drive_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= DS_OFF;
            side_q         <= SIDE_NONE;
            powered        <= 1'b0;
            reverse_mode   <= 1'b0;
            turn_left_led  <= 1'b0;
            turn_right_led <= 1'b0;
            mileage        <= '0;
        end else begin
            state        <= next_state;
            side_q       <= side;
            powered      <= !going_off;
            reverse_mode <= going_off ? 1'b0 : reverse;

            if (going_off) begin
                mileage <= '0;
            end else if (unit_tick && mileage != MILEAGE_MAX) begin
                mileage <= mileage + 16'd1;
            end

            // A newly selected side always starts in the lit phase.
            if (side == SIDE_NONE) begin
                turn_left_led  <= 1'b0;
                turn_right_led <= 1'b0;
            end else if (newly_selected) begin
                turn_left_led  <= (side == SIDE_LEFT);
                turn_right_led <= (side == SIDE_RIGHT);
            end else if (blink_tick) begin
                if (side == SIDE_LEFT) turn_left_led <= !turn_left_led;
                else turn_right_led <= !turn_right_led;
            end
        end
    end

endmodule

// File: tb/tb_manual_drive_fsm.sv
// Directed bench for manual_drive_fsm with a cycle-level behavioural model
// compared on every falling edge, plus literal expectations at key points.
module tb_manual_drive_fsm;

    localparam int HOLD  = 4;
    localparam int UNIT  = 3;
    localparam int BLINK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        power_on, power_off, throttle, clutch, brake, reverse, left, right;
    logic [1:0]  drive_state;
    logic        powered, reverse_mode, turn_left_led, turn_right_led;
    logic [15:0] mileage;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    manual_drive_fsm #(
        .POWER_ON_HOLD (HOLD),
        .UNIT_CYCLES   (UNIT),
        .BLINK_HALF    (BLINK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .power_on       (power_on),
        .power_off      (power_off),
        .throttle       (throttle),
        .clutch         (clutch),
        .brake          (brake),
        .reverse        (reverse),
        .left           (left),
        .right          (right),
        .drive_state    (drive_state),
        .powered        (powered),
        .reverse_mode   (reverse_mode),
        .turn_left_led  (turn_left_led),
        .turn_right_led (turn_right_led),
        .mileage        (mileage)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: 0 OFF, 1 NOT_STARTING, 2 STARTING, 3 MOVING.
    // Mileage derives from total MOVING cycles since power-up; blink phase
    // derives from the number of cycles a side has been held selected.
    int m_state, m_hold, m_moving, m_side, m_prev_side, m_age;
    bit m_rev;

    always @(posedge clk) begin : model
        int nxt;
        if (rst) begin
            m_state = 0; m_hold = 0; m_moving = 0;
            m_side = 0; m_prev_side = 0; m_age = 0; m_rev = 1'b0;
        end else begin
            nxt = m_state;
            if (m_state == 0) begin
                if (power_on && !power_off) begin
                    m_hold++;
                    if (m_hold == HOLD) begin
                        nxt    = 1;
                        m_hold = 0;
                    end
                end else begin
                    m_hold = 0;
                end
            end else if (power_off) begin
                nxt = 0;
            end else if (m_state == 1) begin
                if (!brake && throttle) nxt = clutch ? 2 : 0;
            end else if (m_state == 2) begin
                if (brake) nxt = 1;
                else if (throttle && !clutch) nxt = 3;
            end else begin
                if (brake) nxt = 1;
                else if ((reverse != m_rev) && !clutch) nxt = 0;
                else if (clutch || !throttle) nxt = 2;
            end

            if (m_state == 3) m_moving++;
            if (nxt == 0) m_moving = 0;
            m_rev  = (nxt != 0) ? reverse : 1'b0;
            m_side = (nxt == 0 || left == right) ? 0 : (left ? 1 : 2);
            if (m_side != 0 && m_side == m_prev_side) m_age++;
            else m_age = 0;
            m_prev_side = m_side;
            m_state     = nxt;
        end
    end

    function automatic int exp_mileage();
        return (m_moving / UNIT > 65535) ? 65535 : m_moving / UNIT;
    endfunction

    function automatic bit exp_led(input int which);
        return (m_side == which) && ((m_age / BLINK) % 2 == 0);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_drive_state", drive_state, m_state);
            check("cmp_powered", powered, m_state != 0);
            check("cmp_reverse_mode", reverse_mode, m_rev);
            check("cmp_left_led", turn_left_led, exp_led(1));
            check("cmp_right_led", turn_right_led, exp_led(2));
            check("cmp_mileage", mileage, exp_mileage());
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic power_up();
        power_on = 1'b1;
        cyc(HOLD);
        power_on = 1'b0;
    endtask

    task automatic to_moving();
        throttle = 1'b1; clutch = 1'b1;
        cyc(1);
        clutch = 1'b0;
        cyc(1);
    endtask

    bit blink_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        power_on = 0; power_off = 0; throttle = 0; clutch = 0;
        brake = 0; reverse = 0; left = 0; right = 0;
        cyc(1);
        chk_en = 1'b1;
        cyc(1);
        check("reset_state", drive_state, 2'b00);
        check("reset_powered", powered, 1'b0);
        check("reset_mileage", mileage, 16'd0);
        rst = 1'b0;

        // Interrupted power-on hold must restart from zero.
        power_on = 1; cyc(3);
        check("hold_first_run", drive_state, 2'b00);
        power_on = 0; cyc(1);
        power_on = 1; cyc(3);
        check("hold_second_run_3", drive_state, 2'b00);
        cyc(1);
        check("hold_done", drive_state, 2'b01);
        check("hold_powered", powered, 1'b1);
        power_on = 0;

        // Stall from NOT_STARTING, then start and move.
        throttle = 1; cyc(1);
        check("stall_off", drive_state, 2'b00);
        check("stall_mileage", mileage, 16'd0);
        throttle = 0;
        power_up();
        check("repower", drive_state, 2'b01);
        throttle = 1; clutch = 1; cyc(1);
        check("starting", drive_state, 2'b10);
        clutch = 0; cyc(1);
        check("moving", drive_state, 2'b11);

        // Mileage accumulates, holds across braking, clears at power-off.
        cyc(9);
        check("mileage_after_9", mileage, 16'd3);
        brake = 1; cyc(1);
        check("brake_not_starting", drive_state, 2'b01);
        check("mileage_held", mileage, 16'd3);
        brake = 0; clutch = 1; cyc(1);
        clutch = 0; cyc(1);
        cyc(2);
        check("mileage_partial_kept", mileage, 16'd4);
        throttle = 0; power_off = 1; cyc(1);
        check("power_off_state", drive_state, 2'b00);
        check("power_off_mileage", mileage, 16'd0);
        power_off = 0;

        // Reverse toggle while moving: stall without clutch, shift with clutch.
        power_up();
        to_moving();
        reverse = 1; cyc(1);
        check("reverse_stall", drive_state, 2'b00);
        check("reverse_mode_off", reverse_mode, 1'b0);
        reverse = 0; throttle = 0;
        power_up();
        to_moving();
        clutch = 1; reverse = 1; cyc(1);
        check("reverse_clutch_starting", drive_state, 2'b10);
        check("reverse_mode_follows", reverse_mode, 1'b1);

        // Indicators while parked in STARTING.
        throttle = 0; clutch = 1;
        left = 1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("blink_left", turn_left_led, blink_seq[i]);
            check("blink_left_other", turn_right_led, 1'b0);
        end
        right = 1; cyc(1);
        check("both_left_off", turn_left_led, 1'b0);
        check("both_right_off", turn_right_led, 1'b0);
        left = 0; cyc(1);
        check("right_only_on", turn_right_led, 1'b1);
        left = 1; right = 0; cyc(1);
        check("left_restart_on", turn_left_led, 1'b1);
        power_off = 1; cyc(1);
        check("off_left_led", turn_left_led, 1'b0);
        check("off_state", drive_state, 2'b00);
        cyc(2);
        check("off_left_led_held", turn_left_led, 1'b0);

        // power_on and power_off together never powers up.
        power_on = 1; cyc(10);
        check("both_power_stays_off", drive_state, 2'b00);
        power_off = 0; cyc(HOLD);
        check("power_after_release", drive_state, 2'b01);
        power_on = 0;

        // Reset during MOVING abandons everything.
        reverse = 1;
        to_moving();
        cyc(4);
        check("pre_reset_mileage", mileage, 16'd1);
        rst = 1; cyc(1);
        check("rst_state", drive_state, 2'b00);
        check("rst_powered", powered, 1'b0);
        check("rst_reverse_mode", reverse_mode, 1'b0);
        check("rst_left_led", turn_left_led, 1'b0);
        check("rst_right_led", turn_right_led, 1'b0);
        check("rst_mileage", mileage, 16'd0);
        rst = 0; cyc(2);
        check("no_resume", drive_state, 2'b00);

        // Reset during the power-on hold restarts the hold.
        throttle = 0; left = 0; reverse = 0;
        power_on = 1; cyc(2);
        rst = 1; cyc(1);
        rst = 0; cyc(3);
        check("hold_after_rst_3", drive_state, 2'b00);
        cyc(1);
        check("hold_after_rst_done", drive_state, 2'b01);
        power_on = 0;
        cyc(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
